// File: rtl/btn_debounce_if.sv
// Button bundle between the debouncer and its consumers.
// The slave modport is the debouncer. It takes the raw pins and returns the clean level and strobes.
// The master modport is the other side of that exchange.
interface btn_debounce_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_state;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_state,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_state,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: per channel a 2-FF synchronizer, then a counter-based debounce FSM.
// Outputs are a clean level plus one-cycle press and release strobes.
// Define BTN_DEBOUNCE_LONG_PRESS_EN to build the per-channel hold counter that drives btn_long.
// Without it, btn_long is tied to 0.
module btn_debounce #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input logic           clk_100MHz,
    input logic           reset_n,
    btn_debounce_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] btn_sync;
    state_e           fsm_q [N_BTN];
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [N_BTN-1:0] state_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] accept_high;
    logic [N_BTN-1:0] accept_low;

    // Two-stage synchronizer for the asynchronous button pins.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            btn_sync <= '0;
        end else begin
            sync1_q  <= bus.btn_raw;
            btn_sync <= sync1_q;
        end
    end

    // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive clock at that level.
    always_comb begin
        accept_high = '0;
        accept_low  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            accept_high[i] = (fsm_q[i] == S_WAIT_HIGH) && btn_sync[i] && (cnt_q[i] == CNT_LAST);
            accept_low[i]  = (fsm_q[i] == S_WAIT_LOW) && !btn_sync[i] && (cnt_q[i] == CNT_LAST);
        end
    end

    // Per-channel debounce FSM with registered level and strobes.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                fsm_q[i] <= S_LOW;
                cnt_q[i] <= '0;
            end
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= accept_high;
            release_q <= accept_low;
            for (int i = 0; i < N_BTN; i++) begin
                case (fsm_q[i])
                    S_LOW: begin
                        if (btn_sync[i]) begin
                            fsm_q[i] <= S_WAIT_HIGH;
                            cnt_q[i] <= CNT_ONE;
                        end
                    end
                    S_WAIT_HIGH: begin
                        if (!btn_sync[i]) begin
                            fsm_q[i] <= S_LOW;
                            cnt_q[i] <= '0;
                        end else if (accept_high[i]) begin
                            fsm_q[i]   <= S_HIGH;
                            cnt_q[i]   <= '0;
                            state_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
                    end
                    S_HIGH: begin
                        if (!btn_sync[i]) begin
                            fsm_q[i] <= S_WAIT_LOW;
                            cnt_q[i] <= CNT_ONE;
                        end
                    end
                    S_WAIT_LOW: begin
                        if (btn_sync[i]) begin
                            fsm_q[i] <= S_HIGH;
                            cnt_q[i] <= '0;
                        end else if (accept_low[i]) begin
                            fsm_q[i]   <= S_LOW;
                            cnt_q[i]   <= '0;
                            state_q[i] <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        fsm_q[i] <= S_LOW;
                        cnt_q[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.btn_state   = state_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q [N_BTN];
    logic [N_BTN-1:0]  long_q;

    // Hold counter runs from an accepted press and survives release bounce.
    // It saturates after the single long strobe.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                hold_q[i] <= '0;
            end
            long_q <= '0;
        end else begin
            long_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (accept_high[i] || accept_low[i]) begin
                    hold_q[i] <= '0;
                end else if (fsm_q[i] == S_HIGH || fsm_q[i] == S_WAIT_LOW) begin
                    if (hold_q[i] == HOLD_LAST) begin
                        long_q[i] <= 1'b1;
                        hold_q[i] <= HOLD_MAX;
                    end else if (hold_q[i] != HOLD_MAX) begin
                        hold_q[i] <= hold_q[i] + HOLD_ONE;
                    end
                end
            end
        end
    end

    assign bus.btn_long = long_q;
`else
    // LONG_CYCLES only matters when the hold counter is built.
    localparam int unsigned unused_long_cycles = LONG_CYCLES;

    assign bus.btn_long = '0;
`endif

endmodule
